// File: rtl/multicore_system_pkg.sv
// Shared definitions for the multicore system RAM arbiter: lock-state encoding,
// requester limits and the round-robin pointer helper.
package multicore_system_pkg;

  localparam int unsigned MAX_M = 4;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned IDLE_W = 8;

  typedef enum logic {
    StUnlocked = 1'b0,
    StLocked   = 1'b1
  } lock_state_e;

  // Pointer value that follows requester g, wrapping at num_m.
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] g,
                                               input int unsigned num_m);
    logic [PTR_W-1:0] nxt;
    nxt = g + 1'b1;
    if (32'(g) + 32'd1 >= num_m) begin
      nxt = '0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/multicore_system_rr_grant.sv
// Combinational rotating-priority encoder: the request nearest at or after the
// pointer (modulo NUM_M) wins; output is one-hot or all-zero.
module multicore_system_rr_grant
  import multicore_system_pkg::*;
#(
  parameter int unsigned NUM_M = 2
) (
  input  logic [NUM_M-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NUM_M-1:0] o_grant
);

  int unsigned w_best_dist;
  int unsigned w_best_idx;
  int unsigned w_dist;

  always_comb begin
    w_best_dist = NUM_M;
    w_best_idx  = 0;
    w_dist      = 0;
    o_grant     = '0;
    // Distance from the pointer decides priority; smaller distance wins.
    for (int unsigned i = 0; i < NUM_M; i++) begin
      w_dist = (i + NUM_M - 32'(i_ptr)) % NUM_M;
      if (i_req[i] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_best_idx  = i;
      end
    end
    for (int unsigned i = 0; i < NUM_M; i++) begin
      o_grant[i] = (w_best_dist < NUM_M) && (w_best_idx == i);
    end
  end

endmodule

// File: rtl/multicore_system_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NUM_M Avalon-MM
// requesters, with lock support for atomic sequences and a lock timeout.
module multicore_system_ram_arbiter
  import multicore_system_pkg::*;
#(
  parameter int unsigned NUM_M        = 2,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned LOCK_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_M*ADDR_W-1:0]   m_address,
  input  logic [NUM_M*DATA_W/8-1:0] m_byteenable,
  input  logic [NUM_M-1:0]          m_read,
  input  logic [NUM_M-1:0]          m_write,
  input  logic [NUM_M-1:0]          m_lock,
  input  logic [NUM_M*DATA_W-1:0]   m_writedata,
  output logic [NUM_M-1:0]          m_waitrequest,
  output logic [NUM_M-1:0]          m_readdatavalid,
  output logic [DATA_W-1:0]         m_readdata,
  input  logic                      freeze,
  output logic [ADDR_W-1:0]         ram_address,
  output logic [DATA_W/8-1:0]       ram_byteenable,
  output logic                      ram_chipselect,
  output logic                      ram_write,
  output logic [DATA_W-1:0]         ram_writedata,
  input  logic [DATA_W-1:0]         ram_readdata,
  output logic                      ram_clken
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic [NUM_M-1:0]  w_req;
  logic [NUM_M-1:0]  w_owner_mask;
  logic [NUM_M-1:0]  w_elig;
  logic [NUM_M-1:0]  w_grant;
  logic              w_grant_en;
  logic              w_any_grant;
  logic              w_sel_write;
  logic              w_sel_read;
  logic              w_sel_lock;
  logic              w_owner_req;
  logic [PTR_W-1:0]  w_gidx;

  lock_state_e       r_state, w_state_nxt;
  logic [PTR_W-1:0]  r_owner, w_owner_nxt;
  logic [IDLE_W-1:0] r_idle_cnt, w_idle_cnt_nxt;
  logic [PTR_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic              r_rd_pend;
  logic [PTR_W-1:0]  r_rd_owner;

  assign w_req      = m_read | m_write;
  // Reset is folded in so no grant can leak out while registers are cleared.
  assign w_grant_en = reset_n & ~freeze;

  always_comb begin
    w_owner_mask = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      w_owner_mask[i] = (r_owner == PTR_W'(i));
    end
  end

  always_comb begin
    w_elig = '0;
    if (w_grant_en) begin
      w_elig = (r_state == StLocked) ? (w_req & w_owner_mask) : w_req;
    end
  end

  multicore_system_rr_grant #(
    .NUM_M (NUM_M)
  ) u_rr_grant (
    .i_req   (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant)
  );

  assign w_any_grant   = |w_grant;
  assign w_sel_write   = |(w_grant & m_write);
  // A simultaneous read+write is serviced as a write only.
  assign w_sel_read    = |(w_grant & m_read & ~m_write);
  assign w_sel_lock    = |(w_grant & m_lock);
  assign w_owner_req   = |(w_req & w_owner_mask);
  assign m_waitrequest = w_req & ~w_grant;

  always_comb begin
    w_gidx         = '0;
    ram_address    = '0;
    ram_byteenable = '0;
    ram_writedata  = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (w_grant[i]) begin
        w_gidx         = PTR_W'(i);
        ram_address    = m_address[i*ADDR_W +: ADDR_W];
        ram_byteenable = m_byteenable[i*BE_W +: BE_W];
        ram_writedata  = m_writedata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ram_chipselect = w_any_grant;
  assign ram_write      = w_sel_write;
  assign ram_clken      = 1'b1;

  assign w_rr_ptr_nxt = w_any_grant ? rr_next(w_gidx, NUM_M) : r_rr_ptr;

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_idle_cnt_nxt = r_idle_cnt;
    if (!freeze) begin
      unique case (r_state)
        StUnlocked: begin
          if (w_any_grant && w_sel_lock) begin
            w_state_nxt    = StLocked;
            w_owner_nxt    = w_gidx;
            w_idle_cnt_nxt = '0;
          end
        end
        StLocked: begin
          if (w_owner_req) begin
            // Unfrozen and locked, so the owner's request is always granted.
            w_idle_cnt_nxt = '0;
            if (!w_sel_lock) begin
              w_state_nxt = StUnlocked;
            end
          end else if ((r_idle_cnt + 8'd1) >= 8'(LOCK_TIMEOUT)) begin
            w_state_nxt    = StUnlocked;
            w_idle_cnt_nxt = '0;
          end else begin
            w_idle_cnt_nxt = r_idle_cnt + 8'd1;
          end
        end
        default: w_state_nxt = StUnlocked;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StUnlocked;
      r_owner    <= '0;
      r_idle_cnt <= '0;
      r_rr_ptr   <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_owner <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_rd_pend  <= w_sel_read;
      if (w_sel_read) begin
        r_rd_owner <= w_gidx;
      end
    end
  end

  always_comb begin
    m_readdatavalid = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      m_readdatavalid[i] = r_rd_pend && (r_rd_owner == PTR_W'(i));
    end
  end

  assign m_readdata = ram_readdata;

endmodule

// File: tb/tb_multicore_system_ram_arbiter.sv
// Randomized and directed bench for the RAM arbiter, checked against a
// transaction-level reference model with its own shadow memory.
module tb_multicore_system_ram_arbiter;

  localparam int NM = 2;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NM*AW-1:0]  m_address;
  logic [NM*BW-1:0]  m_byteenable;
  logic [NM-1:0]     m_read, m_write, m_lock;
  logic [NM*DW-1:0]  m_writedata;
  logic [NM-1:0]     m_waitrequest, m_readdatavalid;
  logic [DW-1:0]     m_readdata;
  logic              freeze;
  logic [AW-1:0]     ram_address;
  logic [BW-1:0]     ram_byteenable;
  logic              ram_chipselect, ram_write, ram_clken;
  logic [DW-1:0]     ram_writedata, ram_readdata;

  always #5 clk = ~clk;

  multicore_system_ram_arbiter #(
    .NUM_M        (NM),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .LOCK_TIMEOUT (TO)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .m_address       (m_address),
    .m_byteenable    (m_byteenable),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_lock          (m_lock),
    .m_writedata     (m_writedata),
    .m_waitrequest   (m_waitrequest),
    .m_readdatavalid (m_readdatavalid),
    .m_readdata      (m_readdata),
    .freeze          (freeze),
    .ram_address     (ram_address),
    .ram_byteenable  (ram_byteenable),
    .ram_chipselect  (ram_chipselect),
    .ram_write       (ram_write),
    .ram_writedata   (ram_writedata),
    .ram_readdata    (ram_readdata),
    .ram_clken       (ram_clken)
  );

  // RAM behind the arbiter: byte-enabled, one-cycle registered read.
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] ram_q;
  assign ram_readdata = ram_q;
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < BW; b++) begin
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
        end
      end else begin
        ram_q <= mem[ram_address];
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Stimulus for the next cycle.
  logic [NM-1:0] s_rd, s_wr, s_lk;
  logic [AW-1:0] s_addr [NM];
  logic [BW-1:0] s_be [NM];
  logic [DW-1:0] s_wd [NM];
  logic          s_frz, s_rstn;

  // Reference model state.
  int            md_ptr, md_owner, md_idle, md_powner;
  bit            md_locked, md_pend;
  logic [DW-1:0] md_pdata;
  logic [DW-1:0] ref_mem [1024];

  // Observed DUT outputs of the last step.
  logic [NM-1:0] o_wait, o_rdv;
  logic [DW-1:0] o_rdata;
  logic          o_cs;

  task automatic clr();
    s_rd = '0; s_wr = '0; s_lk = '0; s_frz = 1'b0; s_rstn = 1'b1;
    for (int i = 0; i < NM; i++) begin
      s_addr[i] = '0; s_be[i] = '1; s_wd[i] = '0;
    end
  endtask

  task automatic step();
    int g;
    int idx;
    bit was_locked;
    logic [NM-1:0] exp_wait, exp_rdv;
    @(negedge clk);
    reset_n = s_rstn;
    freeze  = s_frz;
    m_read  = s_rd;
    m_write = s_wr;
    m_lock  = s_lk;
    for (int i = 0; i < NM; i++) begin
      m_address[i*AW +: AW]    = s_addr[i];
      m_byteenable[i*BW +: BW] = s_be[i];
      m_writedata[i*DW +: DW]  = s_wd[i];
    end
    #1;
    o_wait = m_waitrequest; o_rdv = m_readdatavalid; o_rdata = m_readdata; o_cs = ram_chipselect;

    // Expected winner: first eligible requester scanning from the pointer.
    g = -1;
    if (s_rstn && !s_frz) begin
      for (int k = 0; k < NM; k++) begin
        idx = (md_ptr + k) % NM;
        if (g < 0 && (s_rd[idx] || s_wr[idx]) && (!md_locked || idx == md_owner)) g = idx;
      end
    end
    exp_wait = '0;
    for (int i = 0; i < NM; i++) exp_wait[i] = (s_rd[i] | s_wr[i]) && (i != g);
    check_eq("waitrequest", o_wait, exp_wait);
    check_eq("chipselect", o_cs, g >= 0);
    if (g >= 0) begin
      check_eq("ram_write", ram_write, s_wr[g]);
      check_eq("ram_address", ram_address, s_addr[g]);
      check_eq("ram_byteenable", ram_byteenable, s_be[g]);
      if (s_wr[g]) check_eq("ram_writedata", ram_writedata, s_wd[g]);
    end else begin
      check_eq("ram_write_idle", ram_write, 1'b0);
    end
    exp_rdv = '0;
    if (s_rstn && md_pend) exp_rdv[md_powner] = 1'b1;
    check_eq("readdatavalid", o_rdv, exp_rdv);
    if (exp_rdv != '0) check_eq("readdata", o_rdata, md_pdata);

    if (!s_rstn) begin
      md_ptr = 0; md_locked = 0; md_idle = 0; md_pend = 0; md_owner = 0;
    end else begin
      was_locked = md_locked;
      md_pend = 0;
      if (g >= 0) begin
        md_ptr = (g + 1) % NM;
        if (s_wr[g]) begin
          for (int b = 0; b < BW; b++) begin
            if (s_be[g][b]) ref_mem[s_addr[g]][8*b +: 8] = s_wd[g][8*b +: 8];
          end
        end else begin
          md_pend = 1; md_powner = g; md_pdata = ref_mem[s_addr[g]];
        end
      end
      if (!s_frz) begin
        if (!was_locked) begin
          if (g >= 0 && s_lk[g]) begin
            md_locked = 1; md_owner = g; md_idle = 0;
          end
        end else if (s_rd[md_owner] || s_wr[md_owner]) begin
          md_idle = 0;
          if (!s_lk[md_owner]) md_locked = 0;
        end else begin
          md_idle++;
          if (md_idle >= TO) begin
            md_locked = 0; md_idle = 0;
          end
        end
      end
    end
  endtask

  task automatic wr(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [BW-1:0] be);
    clr(); s_wr[m] = 1'b1; s_addr[m] = a; s_wd[m] = d; s_be[m] = be;
    step();
  endtask

  task automatic rd(input int m, input logic [AW-1:0] a);
    clr(); s_rd[m] = 1'b1; s_addr[m] = a;
    step();
  endtask

  int waits;
  int op;

  initial begin
    md_ptr = 0; md_owner = 0; md_idle = 0; md_powner = 0;
    md_locked = 0; md_pend = 0; md_pdata = '0;

    // Reset: requests must all see waitrequest, no chipselect.
    clr(); s_rstn = 1'b0; s_rd = '1;
    step(); step();
    check_eq("rst_wait", o_wait, 2'b11);
    check_eq("rst_cs", o_cs, 1'b0);
    check_eq("clken", ram_clken, 1'b1);

    // Preload a small window so every later read has known contents.
    for (int a = 0; a < 16; a++) begin
      wr(a % NM, 10'(a), (a == 5) ? 32'hDEADBEEF : (a == 9) ? 32'hAABBCCDD : $urandom, 4'hF);
    end

    // Uncontended read.
    rd(0, 10'h005);
    check_eq("unc_wait", o_wait[0], 1'b0);
    clr(); step();
    check_eq("unc_rdv", o_rdv, 2'b01);
    check_eq("unc_data", o_rdata, 32'hDEADBEEF);

    // Byte-enabled write then readback.
    wr(1, 10'h009, 32'h11223344, 4'b0101);
    rd(1, 10'h009);
    clr(); step();
    check_eq("byte_rdv", o_rdv, 2'b10);
    check_eq("byte_data", o_rdata, 32'hAA22CC44);

    // Read returned even while frozen.
    rd(0, 10'h005);
    clr(); s_frz = 1'b1; s_rd = 2'b11; step();
    check_eq("frz_wait", o_wait, 2'b11);
    check_eq("frz_cs", o_cs, 1'b0);
    check_eq("frz_rdv", o_rdv, 2'b01);
    check_eq("frz_data", o_rdata, 32'hDEADBEEF);

    // Lock held by m0 until it writes with lock=0.
    clr(); s_rd[0] = 1'b1; s_lk[0] = 1'b1; s_addr[0] = 10'h005; step();
    clr(); s_rd[1] = 1'b1; s_addr[1] = 10'h006;
    step(); check_eq("lk_hold1", o_wait[1], 1'b1);
    step(); check_eq("lk_hold2", o_wait[1], 1'b1);
    s_wr[0] = 1'b1; s_addr[0] = 10'h007; s_wd[0] = 32'h0BADF00D;
    step(); check_eq("lk_unlock_wait", o_wait, 2'b10);
    s_wr[0] = 1'b0;
    step(); check_eq("lk_grant_next", o_wait[1], 1'b0);

    // Lock timeout: owner goes idle, m1 must wait exactly TO cycles.
    clr(); s_rd[0] = 1'b1; s_lk[0] = 1'b1; s_addr[0] = 10'h003; step();
    clr(); s_rd[1] = 1'b1; s_addr[1] = 10'h004;
    waits = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!o_wait[1]) break;
      waits++;
    end
    check_eq("lock_timeout_waits", waits, TO);
    clr(); step();

    // Reset right after a read is accepted: its data valid is dropped.
    rd(0, 10'h005);
    clr(); s_rstn = 1'b0; step();
    check_eq("rst_mid_rdv", o_rdv, 2'b00);
    step();

    // Contention from rr_ptr = 0: grants alternate 0,1,0,1...
    for (int k = 0; k < 6; k++) begin
      clr(); s_wr = 2'b11;
      s_addr[0] = 10'h00A; s_wd[0] = 32'h1000_0000 + k;
      s_addr[1] = 10'h00B; s_wd[1] = 32'h2000_0000 + k;
      step();
      check_eq("cont_wait", o_wait, (k % 2 == 0) ? 2'b10 : 2'b01);
    end
    rd(0, 10'h00A);
    rd(1, 10'h00B);
    check_eq("cont_rdv0", o_rdv, 2'b01);
    check_eq("cont_m0_data", o_rdata, 32'h1000_0004);
    clr(); step();
    check_eq("cont_rdv1", o_rdv, 2'b10);
    check_eq("cont_m1_data", o_rdata, 32'h2000_0005);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      clr();
      for (int i = 0; i < NM; i++) begin
        op = $urandom_range(0, 9);
        s_rd[i] = (op >= 4 && op <= 6) || op == 9;
        s_wr[i] = (op >= 7);
        s_lk[i] = ($urandom_range(0, 2) == 0);
        s_addr[i] = 10'($urandom_range(0, 15));
        s_be[i] = 4'($urandom);
        s_wd[i] = $urandom;
      end
      s_frz  = ($urandom_range(0, 7) == 0);
      s_rstn = ($urandom_range(0, 149) != 0);
      step();
    end
    clr(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicore_system_ram_arbiter.md
# multicore_system_ram_arbiter

Round-robin arbiter that shares one core's single-port on-chip RAM (1024 x 32, byte-enabled, one-cycle read latency) between several Avalon-MM requesters, e.g. the core's data master and the inter-core mailbox/DMA master. It sits between the system interconnect and the RAM wrapper: it drives the RAM's single port and returns per-requester waitrequest and readdatavalid. It supports a lock for atomic read-modify-write sequences, with a timeout so an abandoned lock cannot stall the other requesters.

## Interface
- NUM_M, 2: number of requesters, 2..4.
- ADDR_W, 10: word address width.
- DATA_W, 32: data width; byteenable width is DATA_W/8.
- LOCK_TIMEOUT, 16: idle owner cycles before a held lock is forcibly released, 1..255.

Ports:
- clk  in  1  single system clock; all logic rises on it.
- reset_n  in  1  asynchronous, active-low reset.
- m_address  in  NUM_M*ADDR_W  per-requester word address, requester i in slice i.
- m_byteenable  in  NUM_M*DATA_W/8  per-requester byte enables.
- m_read, m_write  in  NUM_M each  per-requester read/write strobes; both high together is illegal.
- m_lock  in  NUM_M  hold the grant after this transfer.
- m_writedata  in  NUM_M*DATA_W  write data.
- m_waitrequest  out  NUM_M  transfer not accepted this cycle.
- m_readdatavalid  out  NUM_M  read data valid.
- m_readdata  out  DATA_W  shared read data bus, qualified by m_readdatavalid.
- freeze  in  1  when high, no new grants are issued.
- ram_address  out  ADDR_W  RAM port address.
- ram_byteenable  out  DATA_W/8  RAM byte enables.
- ram_chipselect, ram_write  out  1  RAM strobes.
- ram_writedata  out  DATA_W  RAM write data.
- ram_readdata  in  DATA_W  RAM q, valid one cycle after the address edge.
- ram_clken  out  1  constant 1.

## Operation
- Request from requester i: m_read[i] | m_write[i].
- Each cycle, at most one request is granted.
  - Grant is combinational from the live requests, the registered rr_ptr and the lock state.
  - Priority order: rr_ptr, rr_ptr+1, … modulo NUM_M.
- m_waitrequest[i] = request[i] & ~grant[i]. The granted transfer is accepted that cycle.
- RAM outputs carry the granted requester's address, byteenable, writedata and write. ram_chipselect = (any grant).
- With no grant, ram_chipselect = 0 and ram_write = 0. Address and data outputs hold don't-care values (implementations drive 0).
- After acceptance by requester g, rr_ptr <= (g+1) mod NUM_M. rr_ptr does not change on cycles with no grant.
- Lock state machine, states UNLOCKED and LOCKED(owner):
  - UNLOCKED -> LOCKED(g): on an accepted transfer from g with m_lock[g] = 1.
  - LOCKED(o): only o may be granted; every other requester waits.
  - LOCKED(o) -> UNLOCKED: on an accepted transfer from o with m_lock[o] = 0.
  - LOCKED(o) -> UNLOCKED: when idle_cnt reaches LOCK_TIMEOUT.
  - idle_cnt counts consecutive cycles in which o makes no request, and resets to 0 on any request from o.
  - A locked transfer still advances rr_ptr.
- freeze = 1: grant is 0 for all requesters.
  - The lock state is held and idle_cnt does not count.
  - A read already issued still returns its data.
- Read return:
  - When a read is accepted in cycle N, rd_pend and rd_owner are registered.
  - In cycle N+1, m_readdatavalid[rd_owner] = 1 and m_readdata = ram_readdata.
  - Back-to-back reads, including reads from different requesters, return in order, one per cycle.
  - A write accepted in cycle N+1 does not disturb the return of an N read.
- Illegal read+write on the same requester: treated as a write. No readdatavalid is produced.

## Timing
- Accept latency is 0 cycles for an uncontended request. Read data latency is exactly 1 cycle after acceptance.
- Sustained throughput is one transfer per cycle.
- A contending requester waits at most NUM_M-1 grants when unlocked, plus the lock hold time (bounded by the owner's activity or LOCK_TIMEOUT).
- Reset values: rr_ptr = 0, state UNLOCKED, idle_cnt = 0, rd_pend = 0, all m_readdatavalid = 0.
- During reset, m_waitrequest = request (no grants) and ram_chipselect = 0.
- Reset mid-read: the pending readdatavalid is dropped, never emitted.

## Structure
- Shared package multicore_system_pkg holds the lock-state encoding (UNLOCKED, LOCKED) and the MAX_M = 4 constant.
- Sub-module multicore_system_rr_grant holds the combinational rotating priority encoder: requests plus pointer in, one-hot grant out.
- The top level holds the lock FSM, idle counter, rr_ptr, read-return register and muxing.

## Test plan
- Uncontended read: m0 reads addr 0x005 holding 0xDEADBEEF.
  - m_waitrequest[0] = 0 in cycle N.
  - m_readdatavalid[0] = 1 with 0xDEADBEEF in N+1.
- Contention with NUM_M = 2: m0 and m1 both write continuously, starting from rr_ptr = 0.
  - Grants alternate 0,1,0,1.
  - Each requester sees waitrequest on every other cycle.
  - The RAM contents match the accepted writes.
- Byte write: m1 writes 0x11223344 with byteenable 0b0101 to a word holding 0xAABBCCDD.
  - A readback returns 0xAA22CC44.
- Lock: m0 reads with lock=1, m1 requests continuously.
  - m1 waits until m0 writes with lock=0.
  - m1 is granted in the next cycle.
- Lock timeout: m0 takes the lock then goes idle.
  - m1 is granted exactly after LOCK_TIMEOUT = 16 idle cycles.
- Reset mid-read and freeze:
  - reset_n is asserted in the cycle after a read is accepted: no readdatavalid is seen.
  - Afterwards rr_ptr = 0.
  - freeze = 1 with pending requests gives no grants and ram_chipselect = 0.
